// File: rtl/sockit_spi_pkg.sv
// Shared types for the SPI stream arbiter: owner encoding, FSM states and
// command-word bit positions (counted down from the MSB of the command word).
package sockit_spi_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_XIP  = 2'b01,
    OWN_REG  = 2'b10
  } owner_t;

  typedef enum logic [1:0] {
    IDL = 2'b00,
    OWN = 2'b01,
    DRN = 2'b10
  } fsm_t;

  // command bit = CDW - offset
  localparam int END_OFS = 1;  // END: release slave select after this command
  localparam int RD_OFS  = 2;  // RD : one sdr beat comes back for this command

endpackage

// File: rtl/sockit_spi_if.sv
// Valid/ready stream. Modport s receives (sink), modport d drives (source).
interface sockit_spi_if #(
  parameter int DW = 32
);
  logic [DW-1:0] dat;
  logic          vld;
  logic          rdy;

  modport s (input dat, input vld, output rdy);
  modport d (output dat, output vld, input rdy);
endinterface

// File: rtl/sockit_spi_str_mux.sv
// 2:1 stream mux. in_vld/in_dat from two sources, selected one forwarded to
// out; out_rdy steered back to the selected source only. blk kills both
// directions of the handshake. Used as a demux by swapping handshake roles:
// the sinks' rdy go in on in_vld, the source's vld comes in on out_rdy.
module sockit_spi_str_mux #(
  parameter int DW = 32
) (
  input  logic               sel,
  input  logic               blk,
  input  logic [1:0]         in_vld,
  input  logic [1:0][DW-1:0] in_dat,
  output logic [1:0]         in_rdy,
  output logic               out_vld,
  output logic [DW-1:0]      out_dat,
  input  logic               out_rdy
);

  assign out_vld = in_vld[sel] & ~blk;
  assign out_dat = in_dat[sel];
  assign in_rdy  = {out_rdy & sel & ~blk, out_rdy & ~sel & ~blk};

endmodule

// File: rtl/sockit_spi_arb.sv
// Arbiter sharing one SPI serializer (scw/sdw/sdr) between the XIP engine and
// the CPU register queue. Ownership lasts from grant to the END command plus
// draining of all outstanding read beats.
// Optional: define SOCKIT_SPI_ARB_RR_EN for round-robin tie breaking in IDL;
// otherwise XIP has fixed priority.
module sockit_spi_arb
  import sockit_spi_pkg::*;
#(
  parameter int CDW = 32,
  parameter int DDW = 32,
  parameter int ODW = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  sockit_spi_if.s    xip_scw,
  sockit_spi_if.s    xip_sdw,
  sockit_spi_if.d    xip_sdr,
  sockit_spi_if.s    reg_scw,
  sockit_spi_if.s    reg_sdw,
  sockit_spi_if.d    reg_sdr,
  sockit_spi_if.d    spi_scw,
  sockit_spi_if.d    spi_sdw,
  sockit_spi_if.s    spi_sdr,
  output logic [1:0] own,
  output logic       err
);

  localparam int             END_B   = CDW - END_OFS;
  localparam int             RD_B    = CDW - RD_OFS;
  localparam logic [ODW-1:0] CNT_MAX = '1;

  fsm_t           st, st_nx;
  owner_t         own_q, own_nx;
  logic [ODW-1:0] cnt;
  logic           sel, cnt_zero, head_rd, pick_xip;
  logic           scw_blk, scw_vld, scw_acc, inc, dec;
  logic [CDW-1:0] scw_dat;
  logic [1:0]     scw_rdy, sdw_rdy, sdr_vld;
  logic           sdw_vld;
  logic [DDW-1:0] sdw_dat, sdr_dat;
  logic           sdr_rdy_rt;

  assign sel      = (own_q == OWN_REG);
  assign cnt_zero = (cnt == '0);
  // RD bit of the owner's pending command, needed before the mux output
  assign head_rd  = sel ? reg_scw.dat[RD_B] : xip_scw.dat[RD_B];
  assign scw_blk  = (st != OWN) | ((cnt == CNT_MAX) & head_rd);

  sockit_spi_str_mux #(.DW(CDW)) u_scw (
    .sel     (sel),
    .blk     (scw_blk),
    .in_vld  ({reg_scw.vld, xip_scw.vld}),
    .in_dat  ({reg_scw.dat, xip_scw.dat}),
    .in_rdy  (scw_rdy),
    .out_vld (scw_vld),
    .out_dat (scw_dat),
    .out_rdy (spi_scw.rdy)
  );

  sockit_spi_str_mux #(.DW(DDW)) u_sdw (
    .sel     (sel),
    .blk     (st == IDL),
    .in_vld  ({reg_sdw.vld, xip_sdw.vld}),
    .in_dat  ({reg_sdw.dat, xip_sdw.dat}),
    .in_rdy  (sdw_rdy),
    .out_vld (sdw_vld),
    .out_dat (sdw_dat),
    .out_rdy (spi_sdw.rdy)
  );

  // read return path: demux, so the handshake roles are swapped
  sockit_spi_str_mux #(.DW(DDW)) u_sdr (
    .sel     (sel),
    .blk     ((st == IDL) | cnt_zero),
    .in_vld  ({reg_sdr.rdy, xip_sdr.rdy}),
    .in_dat  ({spi_sdr.dat, spi_sdr.dat}),
    .in_rdy  (sdr_vld),
    .out_vld (sdr_rdy_rt),
    .out_dat (sdr_dat),
    .out_rdy (spi_sdr.vld)
  );

  assign xip_scw.rdy = scw_rdy[0];
  assign reg_scw.rdy = scw_rdy[1];
  assign xip_sdw.rdy = sdw_rdy[0];
  assign reg_sdw.rdy = sdw_rdy[1];
  assign spi_scw.vld = scw_vld;
  assign spi_scw.dat = scw_dat;
  assign spi_sdw.vld = sdw_vld;
  assign spi_sdw.dat = sdw_dat;
  assign xip_sdr.vld = sdr_vld[0];
  assign reg_sdr.vld = sdr_vld[1];
  assign xip_sdr.dat = sdr_dat;
  assign reg_sdr.dat = sdr_dat;
  // unexpected beats are swallowed so the serializer never stalls on them
  assign spi_sdr.rdy = cnt_zero ? spi_sdr.vld : sdr_rdy_rt;

  assign scw_acc = scw_vld & spi_scw.rdy;
  assign inc     = scw_acc & scw_dat[RD_B];
  assign dec     = spi_sdr.vld & sdr_rdy_rt & ~cnt_zero;
  assign own     = own_q;

`ifdef SOCKIT_SPI_ARB_RR_EN
  owner_t last_q;
  assign pick_xip = xip_scw.vld & (~reg_scw.vld | (last_q == OWN_REG));

  // remember who was granted last for tie breaking
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                          last_q <= OWN_REG;
    else if (st == IDL && st_nx == OWN)  last_q <= own_nx;
`else
  assign pick_xip = xip_scw.vld;
`endif

  // next state and owner
  always_comb begin
    st_nx  = st;
    own_nx = own_q;
    case (st)
      IDL: begin
        if (pick_xip) begin
          st_nx  = OWN;
          own_nx = OWN_XIP;
        end else if (reg_scw.vld) begin
          st_nx  = OWN;
          own_nx = OWN_REG;
        end
      end
      OWN: if (scw_acc && scw_dat[END_B]) st_nx = DRN;
      DRN: begin
        if (cnt_zero || (cnt == ODW'(1) && dec)) begin
          st_nx  = IDL;
          own_nx = OWN_NONE;
        end
      end
      default: begin
        st_nx  = IDL;
        own_nx = OWN_NONE;
      end
    endcase
  end

  // state and owner registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st    <= IDL;
      own_q <= OWN_NONE;
    end else begin
      st    <= st_nx;
      own_q <= own_nx;
    end

  // outstanding read counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)           cnt <= '0;
    else if (inc && !dec) cnt <= cnt + ODW'(1);
    else if (dec && !inc) cnt <= cnt - ODW'(1);

  // sticky flag for read beats nobody asked for
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                       err <= 1'b0;
    else if (spi_sdr.vld && cnt_zero) err <= 1'b1;

endmodule

// File: tb/tb_sockit_spi_arb.sv
// Bench for sockit_spi_arb: directed scenarios with literal expectations plus
// a randomized run, all shadowed every cycle by a transaction-level model.
module tb_sockit_spi_arb;
  localparam int CDW  = 32;
  localparam int DDW  = 32;
  localparam int ODW  = 3;
  localparam int MAXC = (1 << ODW) - 1;
`ifdef SOCKIT_SPI_ARB_RR_EN
  localparam int TIE_OWN = 2;
`else
  localparam int TIE_OWN = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] own;
  logic       err;

  always #5 clk = ~clk;

  sockit_spi_if #(.DW(CDW)) xip_scw ();
  sockit_spi_if #(.DW(DDW)) xip_sdw ();
  sockit_spi_if #(.DW(DDW)) xip_sdr ();
  sockit_spi_if #(.DW(CDW)) reg_scw ();
  sockit_spi_if #(.DW(DDW)) reg_sdw ();
  sockit_spi_if #(.DW(DDW)) reg_sdr ();
  sockit_spi_if #(.DW(CDW)) spi_scw ();
  sockit_spi_if #(.DW(DDW)) spi_sdw ();
  sockit_spi_if #(.DW(DDW)) spi_sdr ();

  sockit_spi_arb #(.CDW(CDW), .DDW(DDW), .ODW(ODW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .xip_scw (xip_scw),
    .xip_sdw (xip_sdw),
    .xip_sdr (xip_sdr),
    .reg_scw (reg_scw),
    .reg_sdw (reg_sdw),
    .reg_sdr (reg_sdr),
    .spi_scw (spi_scw),
    .spi_sdw (spi_sdw),
    .spi_sdr (spi_sdr),
    .own     (own),
    .err     (err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_own, m_cnt, m_last;
  bit m_end, m_err;

  task automatic model_step();
    logic [31:0] hd;
    bit hv, hold, acc, dec, xo, sv, srdy, px;
    chk("m_own", own, m_own);
    chk("m_err", err, m_err);
    if (m_own == 0) begin
      chk("m_i_scw_v", spi_scw.vld, 0);
      chk("m_i_sdw_v", spi_sdw.vld, 0);
      chk("m_i_rdy", {xip_scw.rdy, xip_sdw.rdy, reg_scw.rdy, reg_sdw.rdy}, 0);
      chk("m_i_sdr_v", {xip_sdr.vld, reg_sdr.vld}, 0);
      chk("m_i_sdr_rdy", spi_sdr.rdy, spi_sdr.vld);
      if (spi_sdr.vld) m_err = 1;
`ifdef SOCKIT_SPI_ARB_RR_EN
      px = xip_scw.vld && (!reg_scw.vld || m_last == 2);
`else
      px = xip_scw.vld;
`endif
      if (px) begin m_own = 1; m_last = 1; end
      else if (reg_scw.vld) begin m_own = 2; m_last = 2; end
    end else begin
      xo   = (m_own == 1);
      hd   = xo ? xip_scw.dat : reg_scw.dat;
      hv   = xo ? xip_scw.vld : reg_scw.vld;
      hold = m_end || (m_cnt == MAXC && hd[30]);
      chk("m_scw_v", spi_scw.vld, hv && !hold);
      if (hv && !hold) chk("m_scw_d", spi_scw.dat, hd);
      chk("m_scw_rdy_o", xo ? xip_scw.rdy : reg_scw.rdy, spi_scw.rdy && !hold);
      chk("m_scw_rdy_n", xo ? reg_scw.rdy : xip_scw.rdy, 0);
      sv = xo ? xip_sdw.vld : reg_sdw.vld;
      chk("m_sdw_v", spi_sdw.vld, sv);
      if (sv) chk("m_sdw_d", spi_sdw.dat, xo ? xip_sdw.dat : reg_sdw.dat);
      chk("m_sdw_rdy_o", xo ? xip_sdw.rdy : reg_sdw.rdy, spi_sdw.rdy);
      chk("m_sdw_rdy_n", xo ? reg_sdw.rdy : xip_sdw.rdy, 0);
      srdy = xo ? xip_sdr.rdy : reg_sdr.rdy;
      dec  = 0;
      if (m_cnt > 0) begin
        chk("m_sdr_v", xo ? xip_sdr.vld : reg_sdr.vld, spi_sdr.vld);
        if (spi_sdr.vld) chk("m_sdr_d", xo ? xip_sdr.dat : reg_sdr.dat, spi_sdr.dat);
        chk("m_sdr_rdy", spi_sdr.rdy, srdy);
        dec = spi_sdr.vld && srdy;
      end else begin
        chk("m_sdr_v0", xo ? xip_sdr.vld : reg_sdr.vld, 0);
        chk("m_sdr_rdy0", spi_sdr.rdy, spi_sdr.vld);
        if (spi_sdr.vld) m_err = 1;
      end
      chk("m_sdr_vn", xo ? reg_sdr.vld : xip_sdr.vld, 0);
      acc = hv && !hold && spi_scw.rdy;
      if (m_end && (m_cnt == 0 || (m_cnt == 1 && dec))) begin m_own = 0; m_end = 0; end
      if (acc && hd[31]) m_end = 1;
      m_cnt = m_cnt + ((acc && hd[30]) ? 1 : 0) - (dec ? 1 : 0);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_own = 0; m_cnt = 0; m_end = 0; m_err = 0; m_last = 2;
    end else model_step();
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_in();
    xip_scw.vld = 0; xip_scw.dat = '0; xip_sdw.vld = 0; xip_sdw.dat = '0; xip_sdr.rdy = 0;
    reg_scw.vld = 0; reg_scw.dat = '0; reg_sdw.vld = 0; reg_sdw.dat = '0; reg_sdr.rdy = 0;
    spi_scw.rdy = 0; spi_sdw.rdy = 0; spi_sdr.vld = 0; spi_sdr.dat = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_cmd();
    logic [31:0] c;
    c     = $urandom;
    c[31] = ($urandom_range(0, 7) == 0);
    c[30] = ($urandom_range(0, 1) == 1);
    return c;
  endfunction

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  initial begin
    int sp;
    idle_in();
    rst_n = 0;
    // reset: nothing passes even with requests present
    tick();
    xip_scw.vld = 1; spi_scw.rdy = 1; xip_sdr.rdy = 1; spi_sdw.rdy = 1;
    #3;
    chk("rst_own", own, 0);
    chk("rst_err", err, 0);
    chk("rst_scw_v", spi_scw.vld, 0);
    chk("rst_sdw_v", spi_sdw.vld, 0);
    chk("rst_rdy", {xip_scw.rdy, xip_sdw.rdy, reg_scw.rdy, reg_sdw.rdy, spi_sdr.rdy}, 0);
    chk("rst_sdr_v", {xip_sdr.vld, reg_sdr.vld}, 0);
    idle_in();
    tick();
    rst_n = 1;

    // simultaneous request, XIP first, REG held until XIP drained
    xip_scw.vld = 1; xip_scw.dat = 32'h1; reg_scw.vld = 1; reg_scw.dat = 32'h2;
    spi_scw.rdy = 1; xip_sdr.rdy = 1; reg_sdr.rdy = 1;
    #3; chk("t2_idle_own", own, 0); chk("t2_idle_rdy", xip_scw.rdy, 0);
    tick(); #3;
    chk("t2_own_xip", own, 1); chk("t2_reg_rdy", reg_scw.rdy, 0); chk("t2_scw_d", spi_scw.dat, 32'h1);
    tick(); xip_scw.dat = 32'hC000_0000; #3; chk("t2_end_v", spi_scw.vld, 1);
    tick(); xip_scw.dat = 32'h3; #3;
    chk("t2_drn_own", own, 1); chk("t2_drn_v", spi_scw.vld, 0);
    chk("t2_drn_rrdy", reg_scw.rdy, 0); chk("t2_drn_xrdy", xip_scw.rdy, 0);
    tick(); spi_sdr.vld = 1; spi_sdr.dat = 32'h1234_5678; #3;
    chk("t2_sdr_v", xip_sdr.vld, 1); chk("t2_sdr_d", xip_sdr.dat, 32'h1234_5678); chk("t2_rsdr_v", reg_sdr.vld, 0);
    tick(); spi_sdr.vld = 0; #3; chk("t2_idle2", own, 0);
    tick(); #3; chk("t2_tie", own, TIE_OWN);
    tick(); xip_scw.dat = 32'h8000_0000; reg_scw.dat = 32'h8000_0000;
    tick(); idle_in();
    repeat (4) tick();

    // XIP only, one read
    xip_scw.vld = 1; xip_scw.dat = 32'h0B12_3456; spi_scw.rdy = 1; spi_sdw.rdy = 1; xip_sdr.rdy = 1;
    #3; chk("t1_idle_own", own, 0); chk("t1_idle_rdy", xip_scw.rdy, 0);
    tick(); #3;
    chk("t1_own", own, 1); chk("t1_scw_v", spi_scw.vld, 1);
    chk("t1_scw_d", spi_scw.dat, 32'h0B12_3456); chk("t1_rdy", xip_scw.rdy, 1);
    tick(); xip_scw.dat = 32'hC000_0000; #3; chk("t1_end_d", spi_scw.dat, 32'hC000_0000);
    tick(); xip_scw.vld = 0; spi_sdr.vld = 1; spi_sdr.dat = 32'hDEAD_BEEF; #3;
    chk("t1_sdr_v", xip_sdr.vld, 1); chk("t1_sdr_d", xip_sdr.dat, 32'hDEAD_BEEF);
    chk("t1_rsdr_v", reg_sdr.vld, 0); chk("t1_sdr_rdy", spi_sdr.rdy, 1); chk("t1_own_drn", own, 1);
    tick(); spi_sdr.vld = 0; #3; chk("t1_own_rel", own, 0);
    idle_in(); tick();

    // REG fills the read counter
    reg_scw.vld = 1; reg_scw.dat = 32'h4000_0000; spi_scw.rdy = 1; reg_sdr.rdy = 1;
    tick();
    repeat (7) tick();
    #3; chk("t3_full_v", spi_scw.vld, 0); chk("t3_full_rdy", reg_scw.rdy, 0); chk("t3_own", own, 2);
    tick(); reg_scw.dat = 32'h5; #3; chk("t3_nrd_v", spi_scw.vld, 1); chk("t3_nrd_rdy", reg_scw.rdy, 1);
    tick(); reg_scw.dat = 32'h4000_0000; spi_sdr.vld = 1; spi_sdr.dat = 32'hA5A5_A5A5; #3;
    chk("t3_beat_hold", spi_scw.vld, 0); chk("t3_beat_v", reg_sdr.vld, 1);
    chk("t3_beat_d", reg_sdr.dat, 32'hA5A5_A5A5); chk("t3_beat_xv", xip_sdr.vld, 0);
    tick(); spi_sdr.vld = 0; #3; chk("t3_8th_v", spi_scw.vld, 1);
    tick(); reg_scw.dat = 32'h8000_0000; #3; chk("t3_end_full", spi_scw.vld, 1);
    tick(); reg_scw.vld = 0; spi_sdr.vld = 1;
    for (int i = 0; i < 7; i++) begin
      if (i != 0) tick();
      spi_sdr.dat = i;
      #3; chk("t3_drn_own", own, 2);
    end
    tick(); spi_sdr.vld = 0; #3; chk("t3_rel", own, 0);
    idle_in(); tick();

    // same-cycle inc/dec, END with two reads outstanding
    xip_scw.vld = 1; xip_scw.dat = 32'h4000_0000; spi_scw.rdy = 1; xip_sdr.rdy = 1;
    repeat (3) tick();
    tick(); spi_sdr.vld = 1; #3; chk("t4_both_v", spi_scw.vld, 1); chk("t4_both_sdr", xip_sdr.vld, 1);
    tick(); xip_scw.vld = 0;
    tick(); xip_scw.vld = 1; xip_scw.dat = 32'h8000_0000; spi_sdr.vld = 0;
    tick(); xip_scw.vld = 0; spi_sdr.vld = 1; #3; chk("t4_drn2", own, 1);
    tick(); #3; chk("t4_drn1", own, 1);
    tick(); spi_sdr.vld = 0; #3; chk("t4_rel", own, 0);
    idle_in(); tick();

    // spurious read beat in IDL
    spi_sdr.vld = 1; spi_sdr.dat = 32'hBAD; #3;
    chk("t5_rdy", spi_sdr.rdy, 1); chk("t5_sdr_v", {xip_sdr.vld, reg_sdr.vld}, 0); chk("t5_own", own, 0);
    tick(); spi_sdr.vld = 0; #3; chk("t5_err", err, 1);
    idle_in(); tick();

    // asynchronous reset mid-transfer with 4 reads outstanding
    xip_scw.vld = 1; xip_scw.dat = 32'h4000_0000; spi_scw.rdy = 1; xip_sdr.rdy = 1;
    xip_sdw.vld = 1; spi_sdw.rdy = 1;
    repeat (5) tick();
    xip_scw.dat = 32'h0;
    #1; chk("t6_pre_v", spi_scw.vld, 1); chk("t6_pre_own", own, 1);
    #1; rst_n = 0;
    #1;
    chk("t6_own", own, 0); chk("t6_err", err, 0);
    chk("t6_v", {spi_scw.vld, spi_sdw.vld, xip_sdr.vld, reg_sdr.vld}, 0);
    chk("t6_rdy", {xip_scw.rdy, xip_sdw.rdy, reg_scw.rdy, reg_sdw.rdy, spi_sdr.rdy}, 0);
    idle_in(); tick(); rst_n = 1;

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tick();
      sp = ((i / 250) % 3 == 0) ? 3 : 50;
      xip_scw.vld = pct(60); xip_scw.dat = rnd_cmd();
      reg_scw.vld = pct(60); reg_scw.dat = rnd_cmd();
      xip_sdw.vld = pct(50); xip_sdw.dat = $urandom;
      reg_sdw.vld = pct(50); reg_sdw.dat = $urandom;
      xip_sdr.rdy = pct(70); reg_sdr.rdy = pct(70);
      spi_scw.rdy = pct(70); spi_sdw.rdy = pct(70);
      spi_sdr.vld = pct(sp); spi_sdr.dat = $urandom;
    end
    idle_in();
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sockit_spi_arb.md
Name: sockit_spi_arb

Overview:
- Arbiter sharing one SPI serializer stream set (command scw, data write sdw, data read sdr) between two requesters: the XIP engine and the CPU register queue.
- Grants one requester at a time for a whole SPI transfer, from its first command to its end-of-transfer command, so slave-select framing is never interleaved.
- Returns every read beat to the requester that issued it.
- Sits between sockit_spi_xip / sockit_spi_reg and the serializer.

Parameters:
- CDW, 32: command word width (scw data).
- DDW, 32: data word width (sdw/sdr data).
- ODW, 3: outstanding-read counter width; max outstanding reads is 2**ODW-1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- xip_scw  sockit_spi_if.s  CDW  XIP command stream in
- xip_sdw  sockit_spi_if.s  DDW  XIP write data in
- xip_sdr  sockit_spi_if.d  DDW  XIP read data out
- reg_scw  sockit_spi_if.s  CDW  CPU command stream in
- reg_sdw  sockit_spi_if.s  DDW  CPU write data in
- reg_sdr  sockit_spi_if.d  DDW  CPU read data out
- spi_scw  sockit_spi_if.d  CDW  command to serializer
- spi_sdw  sockit_spi_if.d  DDW  write data to serializer
- spi_sdr  sockit_spi_if.s  DDW  read data from serializer
- own  output  2  current owner: 00 none, 01 XIP, 10 REG
- err  output  1  sticky error: read beat arrived with counter at 0

Behaviour:
- Streams: transfer occurs on vld & rdy.
- Command fields: bit CDW-1 = END (release slave select); bit CDW-2 = RD (one sdr beat expected).
- Reset: fsm=IDL, own=00, cnt=0, err=0; all outputs vld=0, rdy=0.
- Reset applies asynchronously mid-transfer. Partial transfers are abandoned and nothing is replayed.
- FSM IDL:
  - All rdy=0 and all spi vld=0.
  - If xip_scw.vld is set, go OWN with own=01. Otherwise, if reg_scw.vld is set, go OWN with own=10.
  - XIP has fixed priority.
  - Grant is registered, so a first command is accepted 1 cycle after vld at the earliest.
- FSM OWN:
  - Owner's scw, sdw and sdr are connected combinationally to the spi side.
  - Non-owner rdy=0 and non-owner sdr vld=0.
  - If an accepted command has END=1, go DRN.
- FSM DRN:
  - scw is blocked for both requesters; sdw and sdr stay routed to the owner.
  - If cnt==0, or cnt==1 with an sdr beat this cycle, go IDL with own=00 next cycle.
- cnt:
  - Increments on an accepted command with RD=1.
  - Decrements on an spi_sdr transfer.
  - Both in the same cycle: unchanged.
- Full: cnt==2**ODW-1 with RD=1 at the owner's scw head → spi_scw.vld=0 and owner rdy=0 until a decrement. Non-read commands still pass.
- Underflow: spi_sdr.vld with cnt==0 → spi_sdr.rdy=1 (beat dropped, no deadlock), no requester sdr vld, err set. err clears only on reset.
- Back-to-back: IDL→OWN re-arbitration after DRN costs exactly 1 idle cycle.

Optional Feature:
- SOCKIT_SPI_ARB_RR_EN defined: round-robin arbitration. In IDL, when both request, grant goes to the requester not served last. The last-served flag resets to REG, so XIP wins the first tie.
- Undefined: fixed XIP priority as above; no last-served register.

Decomposition:
- Package sockit_spi_pkg:
  - owner enum typedef (OWN_NONE, OWN_XIP, OWN_REG)
  - fsm state enum (IDL, OWN, DRN)
  - localparams for END/RD bit positions, relative to CDW
- Sub-module sockit_spi_str_mux: 2:1 stream mux/demux, instantiated three times (scw, sdw, sdr directions). Select plus a block input force vld/rdy to 0.

Test Plan:
- XIP only: xip_scw sends 0x0B123456 (RD=0) then 0xC0000000 (END=1, RD=1); serializer returns sdr 0xDEADBEEF → xip_sdr gets 0xDEADBEEF, own returns 00 one cycle later, reg_sdr never vld.
- Simultaneous request in IDL from both requesters → own=01 first. REG is granted only after XIP's END command is accepted and its sdr is drained. With RR_EN, the next tie goes to REG.
- REG issues 7 RD commands (ODW=3) with sdr stalled → 8th RD command held (spi_scw.vld=0). Non-RD command accepted. Releasing one sdr beat lets the 8th through.
- Same-cycle increment and decrement at cnt=3 → cnt stays 3. END accepted with cnt=2 → DRN held until 2 beats are returned.
- Spurious spi_sdr.vld in IDL → beat consumed, err=1, no requester output.
- Assert rst_n low during OWN with cnt=4 → own=00, cnt=0, err=0, all vld/rdy=0 immediately, without waiting for a clock edge.
